// File: rtl/i2s_rx_sample_fifo.sv
// Stereo-frame FIFO behind the I2S slave receiver: one entry per recv_over rising edge, FWFT valid/ready read side.
// Optional I2S_RX_FIFO_DROP_FIRST_EN discards the first (possibly partial) frame after reset.
module i2s_rx_sample_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] L_DATA,
    input  logic [DW-1:0] R_DATA,
    input  logic          recv_over,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_l,
    output logic [DW-1:0] out_r,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            recv_over_d;
    logic            overflow_q;
    logic            push_req;
    logic            capture_req;
    logic            pop;
    logic            push;
    logic            drop;

    assign push_req = recv_over & ~recv_over_d;

`ifdef I2S_RX_FIFO_DROP_FIRST_EN
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } cap_state_t;

    cap_state_t state_q;
    cap_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        capture_req = 1'b0;
        case (state_q)
            SYNC:    if (push_req) state_d = RUN;
            RUN:     capture_req = push_req;
            default: state_d = SYNC;
        endcase
    end
`else
    assign capture_req = push_req;
`endif

    assign full      = (count_q == FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a frame when the head leaves in the same cycle.
    assign push      = capture_req & (~full | pop);
    assign drop      = capture_req & full & ~pop;

    assign {out_l, out_r} = mem[rd_ptr];
    assign count          = count_q;
    assign overflow       = overflow_q;

    // NOTE: the sample memory has no reset; stale words are never visible because out_valid gates them.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= {L_DATA, R_DATA};
    end

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            recv_over_d <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            recv_over_d <= recv_over;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_sample_fifo.sv
// Scoreboard bench for i2s_rx_sample_fifo: a queue-level model predicts accepted frames, a monitor pops them on handshakes.
// Honours I2S_RX_FIFO_DROP_FIRST_EN the same way as the design.
module tb_i2s_rx_sample_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef I2S_RX_FIFO_DROP_FIRST_EN
    localparam int DROP = 1;
`else
    localparam int DROP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] l_data = '0;
    logic [DW-1:0] r_data = '0;
    logic          recv_over = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_l;
    logic [DW-1:0] out_r;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    i2s_rx_sample_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .L_DATA    (l_data),
        .R_DATA    (r_data),
        .recv_over (recv_over),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_r     (out_r),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, sticky overflow and the stream of frames that must come out.
    logic [2*DW-1:0] exp_q[$];
    int              m_cnt    = 0;
    bit              m_ovf    = 0;
    bit              m_prev   = 0;
    bit              m_synced = 0;

    always @(posedge clk) begin
        bit new_frame;
        bit take;
        bit drop;
        if (rst) begin
            exp_q.delete();
            m_cnt    = 0;
            m_ovf    = 0;
            m_prev   = 0;
            m_synced = (DROP == 0);
        end else begin
            new_frame = recv_over && !m_prev;
            m_prev    = recv_over;
            take      = (m_cnt > 0) && out_ready;
            drop      = 0;
            if (new_frame && !m_synced) begin
                m_synced  = 1;
                new_frame = 0;
            end
            if (new_frame) begin
                if (m_cnt < DEPTH || take) begin
                    exp_q.push_back({l_data, r_data});
                    m_cnt++;
                end else begin
                    drop = 1;
                end
            end
            if (take) m_cnt--;
            if (drop)         m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Monitor: sampled on the falling edge, away from register updates.
    bit              mon_en   = 0;
    logic [2*DW-1:0] last_pop = '0;

    always @(negedge clk) begin
        logic [2*DW-1:0] want;
        if (mon_en) begin
            check("count", count, m_cnt);
            check("full", full, m_cnt == DEPTH);
            check("out_valid", out_valid, m_cnt != 0);
            check("overflow", overflow, m_ovf);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {out_l, out_r}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    check("head_frame", {out_l, out_r}, want);
                    last_pop = {out_l, out_r};
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        l_data    = l;
        r_data    = r;
        recv_over = 1'b1;
        step();
        recv_over = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step(DEPTH + 2);
        out_ready = 1'b0;
    endtask

    initial begin
        step(2);
        rst    = 1'b0;
        mon_en = 1;

        // Three frames held, then released in order.
        do_reset();
        send_frame(16'hA5A5, 16'h5A5A);
        send_frame(16'h1234, 16'h4321);
        send_frame(16'h0F0F, 16'hF0F0);
        check("t1_count", count, 3 - DROP);
        check("t1_head", {out_l, out_r}, (DROP != 0) ? 32'h1234_4321 : 32'hA5A5_5A5A);
        out_ready = 1'b1;
        step(3 - DROP);
        check("t1_empty_valid", out_valid, 0);
        check("t1_last", last_pop, 32'h0F0F_F0F0);
        out_ready = 1'b0;

        // A long high level is a single push.
        l_data    = 16'h0101;
        r_data    = 16'h0202;
        recv_over = 1'b1;
        step(5);
        recv_over = 1'b0;
        step();
        check("t2_count", count, 1);
        drain();

        // Overfill: ten frames into eight slots.
        for (int i = 1; i <= DEPTH + 2; i++) send_frame(DW'(16'h1000 + i), DW'(16'h2000 + i));
        check("t3_count", count, DEPTH);
        check("t3_full", full, 1);
        check("t3_overflow", overflow, 1);
        check("t3_head", {out_l, out_r}, 32'h1001_2001);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // Push while full with a simultaneous pop.
        l_data    = 16'hBEEF;
        r_data    = 16'hCAFE;
        recv_over = 1'b1;
        out_ready = 1'b1;
        step();
        recv_over = 1'b0;
        out_ready = 1'b0;
        step();
        check("t4_count", count, DEPTH);
        check("t4_overflow", overflow, 0);
        drain();
        check("t4_last", last_pop, 32'hBEEF_CAFE);
        check("t4_drained", count, 0);

        // Pointer wrap: streaming 20 frames.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_frame(DW'($urandom), DW'($urandom));
        step(2);
        check("wrap_last_is_empty", out_valid, 0);
        out_ready = 1'b0;

        // Reset mid-operation.
        for (int i = 0; i < 4; i++) send_frame(DW'(16'h3000 + i), DW'(16'h4000 + i));
        out_ready = 1'b1;
        do_reset();
        out_ready = 1'b0;
        check("t5_count", count, 0);
        check("t5_valid", out_valid, 0);
        send_frame(16'h7777, 16'h8888);
        send_frame(16'h9999, 16'hAAAA);
        check("t5_count2", count, 2 - DROP);
        check("t5_head", {out_l, out_r}, (DROP != 0) ? 32'h9999_AAAA : 32'h7777_8888);

        // First-frame handling after each reset.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_frame(16'hA5A5, 16'h5A5A);
            send_frame(16'h1234, 16'h4321);
            check("t6_count", count, 2 - DROP);
            check("t6_head", {out_l, out_r}, (DROP != 0) ? 32'h1234_4321 : 32'hA5A5_5A5A);
        end
        drain();

        // Randomised traffic: a congested phase then a flowing phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                l_data    = DW'($urandom);
                r_data    = DW'($urandom);
                recv_over = $urandom_range(0, 1) == 1;
                out_ready = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                ovf_clr   = $urandom_range(0, 15) == 0;
                rst       = $urandom_range(0, 299) == 0;
                step();
            end
        end
        rst       = 1'b0;
        recv_over = 1'b0;
        ovf_clr   = 1'b0;
        step();
        drain();
        check("final_count", count, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
